// File: rtl/stdp_pkg.sv
// stdp_pkg: shared phase encoding, config field layout and LFSR constants for the STDP stimulus generator
package stdp_pkg;
  typedef enum logic [1:0] {PH_IDLE = 2'd0, PH_BURST = 2'd1, PH_GAP = 2'd2} phase_t;
  localparam int CFG_AMP_LSB = 4;
  localparam int CFG_ORDER_BIT = 3;
  localparam int CFG_S_MSB = 2;
  localparam logic [7:0] CFG_RST = 8'h80;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [7:0] amp(input logic [7:0] cfg);
    return {cfg[7:CFG_AMP_LSB], 4'b0000};
  endfunction
endpackage

// File: rtl/stdp_stim_lfsr.sv
// stdp_stim_lfsr: 16-bit Fibonacci LFSR with enable, used for current jitter
module stdp_stim_lfsr
  import stdp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (!rst_n) q <= LFSR_SEED;
    else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/stdp_stim_gen.sv
// stdp_stim_gen: staggered burst/gap current sequencer for STDP pre/post neurons
// Optional LFSR current jitter enabled by defining STDP_STIM_JITTER_EN.
module stdp_stim_gen
  import stdp_pkg::*;
#(
  parameter int N_PRE = 4,
  parameter int W = 8,
  parameter int BURST_LEN = 64,
  parameter int GAP_LEN = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [7:0]         cfg_in,
  input  logic               cfg_load,
  output logic [N_PRE*W-1:0] pre_current,
  output logic [W-1:0]       post_current,
  output logic [1:0]         phase,
  output logic               burst_start,
  output logic [7:0]         burst_cnt
);
  phase_t ph, ph_n;
  logic [9:0] t, t_n, len, post_st;
  logic [7:0] shadow, act, act_n, a_n;
  logic [W-1:0] lvl, post_n;
  logic [N_PRE*W-1:0] pre_n;
  logic burst_end, gap_end, enter;
  assign len = 10'(N_PRE) * {7'd0, act[CFG_S_MSB:0]} + 10'(BURST_LEN);
  assign burst_end = ph == PH_BURST && t == len - 10'd1;
  assign gap_end = ph == PH_GAP && t == 10'(GAP_LEN - 1);
  assign enter = run && (ph == PH_IDLE || gap_end);
  assign ph_n = enter ? PH_BURST : burst_end ? PH_GAP : gap_end ? PH_IDLE : ph;
  assign t_n = (ph_n != ph || ph == PH_IDLE) ? 10'd0 : t + 10'd1;
  // a load on the entry cycle bypasses the shadow so it applies to this burst
  assign act_n = enter ? (cfg_load ? cfg_in : shadow) : act;
  assign a_n = amp(act_n);
`ifdef STDP_STIM_JITTER_EN
  logic [15:0] lfsr_q;
  logic [8:0] sum;
  stdp_stim_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .en(1'b1), .q(lfsr_q));
  assign sum = {1'b0, a_n} + {7'd0, lfsr_q[1:0]};
  assign lvl = a_n == 8'd0 ? '0 : sum[8] ? 8'hFF : sum[7:0];
`else
  assign lvl = a_n;
`endif
  // window positions are derived from the next-state config so outputs line up with t
  for (genvar i = 0; i < N_PRE; i++) begin : g_pre
    logic [9:0] st;
    assign st = (act_n[CFG_ORDER_BIT] ? 10'(i + 1) : 10'(i)) * {7'd0, act_n[CFG_S_MSB:0]};
    assign pre_n[i*W +: W] = (ph_n == PH_BURST && t_n >= st && t_n < st + 10'(BURST_LEN)) ? lvl : '0;
  end
  assign post_st = act_n[CFG_ORDER_BIT] ? 10'd0 : 10'(N_PRE) * {7'd0, act_n[CFG_S_MSB:0]};
  assign post_n = (ph_n == PH_BURST && t_n >= post_st && t_n < post_st + 10'(BURST_LEN)) ? lvl : '0;
  assign phase = ph;
  always_ff @(posedge clk)
    if (!rst_n) begin
      ph <= PH_IDLE;
      t <= '0;
      shadow <= CFG_RST;
      act <= CFG_RST;
      burst_start <= 1'b0;
      burst_cnt <= '0;
      pre_current <= '0;
      post_current <= '0;
    end else begin
      ph <= ph_n;
      t <= t_n;
      act <= act_n;
      if (cfg_load) shadow <= cfg_in;
      burst_start <= enter;
      burst_cnt <= burst_cnt + 8'(burst_end);
      pre_current <= pre_n;
      post_current <= post_n;
    end
endmodule

// File: tb/tb_stdp_stim_gen.sv
// tb_stdp_stim_gen: scoreboard bench for stdp_stim_gen; expectations from a behavioural model
module tb_stdp_stim_gen;
  logic clk = 0, rst_n = 0, run = 0, cfg_load = 0;
  logic [7:0] cfg_in = 0;
  logic [31:0] pre_current;
  logic [7:0] post_current, burst_cnt;
  logic [1:0] phase;
  logic burst_start;
  stdp_stim_gen dut (
    .clk(clk), .rst_n(rst_n), .run(run), .cfg_in(cfg_in), .cfg_load(cfg_load),
    .pre_current(pre_current), .post_current(post_current), .phase(phase),
    .burst_start(burst_start), .burst_cnt(burst_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pre;
    logic [7:0] post;
    logic [1:0] ph;
    logic bs;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  int m_ph = 0, m_t = 0, m_cnt = 0;
  logic [7:0] m_sh = 8'h80, m_act = 8'h80;
  logic [15:0] m_lfsr = 16'hACE1;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", tag, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] chan(input int st, input int tt, input logic [7:0] lvl);
    return (tt >= st && tt < st + 64) ? lvl : 8'h00;
  endfunction
  task automatic compare_one();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("pre", pre_current, e.pre);
    check("post", {24'd0, post_current}, {24'd0, e.post});
    check("phase", {30'd0, phase}, {30'd0, e.ph});
    check("burst_start", {31'd0, burst_start}, {31'd0, e.bs});
    check("burst_cnt", {24'd0, burst_cnt}, {24'd0, e.cnt});
  endtask
  task automatic cyc(input logic r, input logic ld, input logic [7:0] c, input logic rn);
    exp_t e;
    logic [7:0] a, lvl;
    logic [8:0] sm;
    bit go;
    int s, len, st;
    @(negedge clk);
    compare_one();
    run = r; cfg_load = ld; cfg_in = c; rst_n = rn;
    e.bs = 0;
    go = 0;
    if (!rn) begin
      m_ph = 0; m_t = 0; m_cnt = 0; m_sh = 8'h80; m_act = 8'h80; m_lfsr = 16'hACE1;
      lvl = 0;
    end else begin
      case (m_ph)
        0: go = r;
        1: begin
          len = 4 * int'(m_act[2:0]) + 64;
          if (m_t == len - 1) begin m_ph = 2; m_t = 0; m_cnt = (m_cnt + 1) % 256; end
          else m_t++;
        end
        default: if (m_t == 127) begin
          if (r) go = 1;
          else begin m_ph = 0; m_t = 0; end
        end else m_t++;
      endcase
      if (go) begin m_act = ld ? c : m_sh; m_ph = 1; m_t = 0; e.bs = 1; end
      if (ld) m_sh = c;
      a = {m_act[7:4], 4'h0};
`ifdef STDP_STIM_JITTER_EN
      sm = {1'b0, a} + {7'd0, m_lfsr[1:0]};
      lvl = (a == 0) ? 8'h00 : sm[8] ? 8'hFF : sm[7:0];
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`else
      sm = {1'b0, a};
      lvl = sm[7:0];
`endif
    end
    e.pre = 0;
    e.post = 0;
    if (m_ph == 1) begin
      s = int'(m_act[2:0]);
      for (int i = 0; i < 4; i++) begin
        st = m_act[3] ? (i + 1) * s : i * s;
        e.pre[i*8 +: 8] = chan(st, m_t, lvl);
      end
      e.post = chan(m_act[3] ? 0 : 4 * s, m_t, lvl);
    end
    e.ph = 2'(m_ph);
    e.cnt = 8'(m_cnt);
    sb.push_back(e);
  endtask
  task automatic wait_state(input int ph, input int tt);
    int n = 0;
    while (!(m_ph == ph && m_t == tt) && n < 4000) begin
      cyc(1, 0, 8'h00, 1);
      n++;
    end
    if (n >= 4000) check("wait_timeout", n, 0);
  endtask
  initial begin
    repeat (3) cyc(0, 0, 8'h00, 0);
    repeat (2) cyc(0, 0, 8'h00, 1);
    repeat (200) cyc(1, 0, 8'h00, 1);
    repeat (300) cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'hA3, 1);
    repeat (210) cyc(1, 0, 8'h00, 1);
    repeat (300) cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'h6A, 1);
    cyc(1, 0, 8'h00, 1);
    wait_state(1, 10);
    cyc(1, 1, 8'hF0, 1);
    wait_state(2, 127);
    cyc(1, 0, 8'h00, 1);
    wait_state(2, 127);
    cyc(1, 1, 8'h25, 1);
    wait_state(1, 10);
    repeat (400) cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'h10, 1);
    repeat (256 * 192 + 5) cyc(1, 0, 8'h00, 1);
    wait_state(1, 30);
    cyc(1, 0, 8'h00, 0);
    repeat (5) cyc(0, 0, 8'h00, 1);
    @(negedge clk);
    compare_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
